// File: rtl/jy_irq_sequencer.sv
// IRQ sequencer for the J.Y. Company mapper family: $C000-$C006 register file,
// enable/disable FSM, selectable tick source and prescaler/counter pair.
module jy_irq_sequencer #(
    parameter bit A12_FILTER = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ce,
    input  logic       ppu_ce,
    input  logic       reg_we,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_din,
    input  logic       prg_write,
    input  logic       chr_a12,
    input  logic       chr_read,
    output logic       irq,
    output logic [7:0] irq_count,
    output logic [7:0] irq_prescaler
);

    typedef enum logic [1:0] {StOff, StArmed, StFired} state_e;

    state_e     state_q, state_d;
    logic       irq_q, irq_d;
    logic [7:0] count_q, count_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] xor_q, xor_d;
    logic [7:0] mode_q, mode_d;
    logic       en_req_q, en_req_d;
    logic       dis_req_q, dis_req_d;
    logic       a12_old_q, a12_old_d;
    logic [1:0] low_run_q, low_run_d;

    logic dir_up, dir_dn, active, a12_rise, src_evt, tick;
    logic presc_wrap, cnt_wrap;

    always_comb begin
        dir_up = (mode_q[7:6] == 2'b01);
        dir_dn = (mode_q[7:6] == 2'b10);
        active = (state_q != StOff);

        // Filtered mode also demands a low run of at least 3 PPU samples.
        a12_rise = ppu_ce & chr_a12 & ~a12_old_q & (!A12_FILTER || (low_run_q == 2'd3));

        unique case (mode_q[1:0])
            2'b00: src_evt = ce;
            2'b01: src_evt = a12_rise;
            2'b10: src_evt = ppu_ce & chr_read;
            2'b11: src_evt = ce & prg_write;
        endcase

        tick = active & (dir_up | dir_dn) & src_evt;

        if (mode_q[2]) begin
            presc_wrap = (presc_q[2:0] == (dir_up ? 3'd7 : 3'd0));
        end else begin
            presc_wrap = (presc_q == (dir_up ? 8'hFF : 8'h00));
        end
        cnt_wrap = (count_q == (dir_up ? 8'hFF : 8'h00));

        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        xor_d     = xor_q;
        mode_d    = mode_q;
        en_req_d  = 1'b0;
        dis_req_d = 1'b0;
        a12_old_d = a12_old_q;
        low_run_d = low_run_q;

        if (ppu_ce) begin
            a12_old_d = chr_a12;
            if (chr_a12) begin
                low_run_d = 2'd0;
            end else if (low_run_q != 2'd3) begin
                low_run_d = low_run_q + 2'd1;
            end
        end

        if (tick) begin
            presc_d = dir_up ? presc_q + 8'd1 : presc_q - 8'd1;
            if (presc_wrap) begin
                count_d = dir_up ? count_q + 8'd1 : count_q - 8'd1;
                if (cnt_wrap && state_q == StArmed) begin
                    state_d = StFired;
                end
            end
        end

        // Latched requests from the previous cycle; disable beats enable and any tick.
        if (dis_req_q) begin
            state_d = StOff;
            presc_d = 8'h00;
        end else if (en_req_q && state_q == StOff) begin
            state_d = StArmed;
        end

        if (reg_we) begin
            case (reg_addr)
                3'd0: begin
                    en_req_d  = reg_din[0];
                    dis_req_d = ~reg_din[0];
                end
                3'd1:    mode_d    = reg_din;
                3'd2:    dis_req_d = 1'b1;
                3'd3:    en_req_d  = 1'b1;
                3'd4:    presc_d   = reg_din ^ xor_q;
                3'd5:    count_d   = reg_din ^ xor_q;
                3'd6:    xor_d     = reg_din;
                default: ;
            endcase
        end

        if (!enable) begin
            state_d   = StOff;
            count_d   = 8'h00;
            presc_d   = 8'h00;
            xor_d     = 8'h00;
            mode_d    = 8'h00;
            en_req_d  = 1'b0;
            dis_req_d = 1'b0;
            a12_old_d = 1'b0;
            low_run_d = 2'd0;
        end

        irq_d = (state_d == StFired);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StOff;
            irq_q     <= 1'b0;
            count_q   <= 8'h00;
            presc_q   <= 8'h00;
            xor_q     <= 8'h00;
            mode_q    <= 8'h00;
            en_req_q  <= 1'b0;
            dis_req_q <= 1'b0;
            a12_old_q <= 1'b0;
            low_run_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            xor_q     <= xor_d;
            mode_q    <= mode_d;
            en_req_q  <= en_req_d;
            dis_req_q <= dis_req_d;
            a12_old_q <= a12_old_d;
            low_run_q <= low_run_d;
        end
    end

    assign irq           = irq_q;
    assign irq_count     = count_q;
    assign irq_prescaler = presc_q;

endmodule

// File: tb/tb_jy_irq_sequencer.sv
// Self-checking bench for jy_irq_sequencer: vector table plus directed multi-cycle sequences.
module tb_jy_irq_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       ce = 1'b0;
    logic       ppu_ce = 1'b0;
    logic       reg_we = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [7:0] reg_din = 8'h00;
    logic       prg_write = 1'b0;
    logic       chr_a12 = 1'b0;
    logic       chr_read = 1'b0;
    logic       irq, irq_f;
    logic [7:0] cnt, cnt_f;
    logic [7:0] pre, pre_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jy_irq_sequencer #(.A12_FILTER(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ce(ce), .ppu_ce(ppu_ce),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din), .prg_write(prg_write),
        .chr_a12(chr_a12), .chr_read(chr_read),
        .irq(irq), .irq_count(cnt), .irq_prescaler(pre)
    );

    jy_irq_sequencer #(.A12_FILTER(1'b1)) dut_f (
        .clk(clk), .reset(reset), .enable(enable), .ce(ce), .ppu_ce(ppu_ce),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din), .prg_write(prg_write),
        .chr_a12(chr_a12), .chr_read(chr_read),
        .irq(irq_f), .irq_count(cnt_f), .irq_prescaler(pre_f)
    );

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] din;
        logic       ce;
        logic       exp_irq;
        logic [7:0] exp_cnt;
        logic [7:0] exp_pre;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_we   = 1'b1;
        reg_addr = a;
        reg_din  = d;
        cyc();
        reg_we = 1'b0;
    endtask

    task automatic a12_sample(input logic a, input logic pce);
        chr_a12 = a;
        ppu_ce  = pce;
        cyc();
        ppu_ce = 1'b0;
    endtask

    initial begin
        int early;

        // 3-bit prescaler up-count from 5 with count FE, then write/tick overlap and freeze.
        vecs[0]  = '{1'b1, 3'd1, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 3'd4, 8'h05, 1'b0, 1'b0, 8'h00, 8'h05};
        vecs[2]  = '{1'b1, 3'd5, 8'hFE, 1'b0, 1'b0, 8'hFE, 8'h05};
        vecs[3]  = '{1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 8'hFE, 8'h05};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFE, 8'h05};
        vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFE, 8'h06};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFE, 8'h07};
        vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h08};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h09};
        vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h0A};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h0B};
        vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h0C};
        vecs[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h0D};
        vecs[13] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h0E};
        vecs[14] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h0F};
        vecs[15] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h10};
        vecs[16] = '{1'b1, 3'd5, 8'h40, 1'b1, 1'b1, 8'h40, 8'h11};
        vecs[17] = '{1'b1, 3'd4, 8'h07, 1'b1, 1'b1, 8'h40, 8'h07};
        vecs[18] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h41, 8'h08};
        vecs[19] = '{1'b1, 3'd1, 8'h04, 1'b1, 1'b1, 8'h41, 8'h09};
        vecs[20] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h41, 8'h09};

        cyc();
        cyc();
        reset = 1'b0;
        chk("reset_irq", {7'd0, irq}, 8'h00);
        chk("reset_count", cnt, 8'h00);
        chk("reset_prescaler", pre, 8'h00);

        for (int i = 0; i < 21; i++) begin
            reg_we   = vecs[i].we;
            reg_addr = vecs[i].addr;
            reg_din  = vecs[i].din;
            ce       = vecs[i].ce;
            cyc();
            reg_we = 1'b0;
            ce     = 1'b0;
            chk($sformatf("vec%0d_irq", i), {7'd0, irq}, {7'd0, vecs[i].exp_irq});
            chk($sformatf("vec%0d_count", i), cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_prescaler", i), pre, vecs[i].exp_pre);
        end

        // Asynchronous reset between clock edges while FIRED with nonzero state.
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_irq", {7'd0, irq}, 8'h00);
        chk("async_reset_count", cnt, 8'h00);
        chk("async_reset_prescaler", pre, 8'h00);
        cyc();
        #2;
        reset = 1'b0;
        cyc();

        // M2 down-count from count 2, prescaler 0: wraps at ticks 1, 257, 513.
        wr(3'd5, 8'h02);
        wr(3'd4, 8'h00);
        wr(3'd1, 8'h80);
        wr(3'd3, 8'h00);
        cyc();
        ce = 1'b1;
        early = 0;
        for (int i = 0; i < 512; i++) begin
            cyc();
            if (irq) early++;
        end
        chk("m2_no_early_irq", early[7:0], 8'h00);
        chk("m2_count_t512", cnt, 8'h00);
        chk("m2_prescaler_t512", pre, 8'h00);
        cyc();
        ce = 1'b0;
        chk("m2_irq_t513", {7'd0, irq}, 8'h01);
        chk("m2_count_t513", cnt, 8'hFF);
        chk("m2_prescaler_t513", pre, 8'hFF);

        // Enable while FIRED is ignored; disable takes two clocks and clears prescaler.
        wr(3'd3, 8'h00);
        cyc();
        chk("enable_in_fired_irq", {7'd0, irq}, 8'h01);
        wr(3'd0, 8'h00);
        chk("disable_latched_irq", {7'd0, irq}, 8'h01);
        cyc();
        chk("disable_irq", {7'd0, irq}, 8'h00);
        chk("disable_prescaler", pre, 8'h00);
        chk("disable_count_kept", cnt, 8'hFF);
        ce = 1'b1;
        cyc();
        ce = 1'b0;
        chk("off_no_tick", pre, 8'h00);
        wr(3'd3, 8'h00);
        cyc();
        ce = 1'b1;
        cyc();
        ce = 1'b0;
        chk("resume_count", cnt, 8'hFE);
        chk("resume_prescaler", pre, 8'hFF);
        chk("resume_irq", {7'd0, irq}, 8'h00);

        // XOR path and ignored address 7.
        wr(3'd6, 8'h5A);
        wr(3'd5, 8'h5A);
        chk("xor_count", cnt, 8'h00);
        wr(3'd4, 8'h0F);
        chk("xor_prescaler", pre, 8'h55);
        wr(3'd6, 8'h00);
        wr(3'd5, 8'h33);
        chk("xor_zero_count", cnt, 8'h33);
        wr(3'd7, 8'hFF);
        chk("addr7_count", cnt, 8'h33);
        chk("addr7_prescaler", pre, 8'h55);

        // Mapper disable behaves as a synchronous clear.
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        chk("enable_low_count", cnt, 8'h00);
        chk("enable_low_prescaler", pre, 8'h00);

        // A12 source, unfiltered and filtered instances side by side.
        wr(3'd1, 8'h41);
        wr(3'd3, 8'h00);
        cyc();
        for (int i = 0; i < 4; i++) begin
            a12_sample(1'b0, 1'b1);
            a12_sample(1'b1, 1'b1);
        end
        chk("a12_four_rises", pre, 8'h04);
        chk("a12f_short_runs", pre_f, 8'h00);
        for (int i = 0; i < 2; i++) begin
            a12_sample(1'b0, 1'b1);
            a12_sample(1'b0, 1'b1);
            a12_sample(1'b1, 1'b1);
        end
        chk("a12_two_sample_runs", pre, 8'h06);
        chk("a12f_two_sample_runs", pre_f, 8'h00);
        a12_sample(1'b0, 1'b1);
        a12_sample(1'b0, 1'b1);
        a12_sample(1'b0, 1'b1);
        a12_sample(1'b1, 1'b1);
        chk("a12_three_sample_run", pre, 8'h07);
        chk("a12f_three_sample_run", pre_f, 8'h01);
        a12_sample(1'b0, 1'b1);
        a12_sample(1'b1, 1'b0);
        a12_sample(1'b0, 1'b0);
        chk("a12_rise_without_ppu_ce", pre, 8'h07);

        // PPU read and CPU write sources.
        wr(3'd1, 8'h42);
        chr_read = 1'b1;
        cyc();
        ppu_ce = 1'b1;
        cyc();
        ppu_ce   = 1'b0;
        chr_read = 1'b0;
        chk("ppu_read_source", pre, 8'h08);
        wr(3'd1, 8'h43);
        prg_write = 1'b1;
        cyc();
        ce = 1'b1;
        cyc();
        ce        = 1'b0;
        prg_write = 1'b0;
        chk("cpu_write_source", pre, 8'h09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
